// File: rtl/onchip_sram_responder_pkg.sv
// Shared constants and types for the on-chip SRAM responder: CSR offsets,
// status bit positions, reset dimensions and the status register layout.
package fecg_mm_pkg;

  localparam logic [1:0] CSR_SIZE_M = 2'd0;
  localparam logic [1:0] CSR_SIZE_N = 2'd1;
  localparam logic [1:0] CSR_SIZE_P = 2'd2;
  localparam logic [1:0] CSR_STATUS = 2'd3;

  localparam int ST_START = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_PROTO = 2;
  localparam int ST_ADDR  = 3;
  localparam int ST_PAR   = 4;

  localparam logic [15:0] DIM_RST = 16'd8;

  // The start bit is a write-only strobe, so it has no storage here.
  typedef struct packed {
    logic par_err;
    logic addr_err;
    logic proto_err;
    logic done;
  } csr_status_t;

endpackage

// File: rtl/onchip_sram_responder_if.sv
// Avalon-MM s2-style port between the matrix accelerator (master) and the
// scratchpad responder (slave), including the global clock enable.
interface onchip_sram_responder_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic                  clk_en;
  logic                  chip_select;
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W/8-1:0]   byte_enable;
  logic [DATA_W-1:0]     write_data;
  logic [DATA_W-1:0]     read_data;
  logic                  valid;

  modport master (
    output clk_en, chip_select, read, write, address, byte_enable, write_data,
    input  read_data, valid
  );

  modport slave (
    input  clk_en, chip_select, read, write, address, byte_enable, write_data,
    output read_data, valid
  );
endinterface

// File: rtl/onchip_sram_responder_sram_bank.sv
// Byte-lane RAM with registered read. With MM_PARITY_EN defined, an even-parity
// bit per byte is stored beside each word and checked on the read register.
module sram_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int AW     = 12
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                par_mis
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (rd_en) rdata <= mem[addr];
  end

`ifdef MM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] par_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) par_mem[addr][i] <= ^wdata[i*8 +: 8];
      end
    end
    if (rd_en) par_q <= par_mem[addr];
  end

  always_comb begin
    par_mis = 1'b0;
    for (int i = 0; i < NB; i++) begin
      par_mis = par_mis | ((^rdata[i*8 +: 8]) ^ par_q[i]);
    end
  end
`else
  assign par_mis = 1'b0;
`endif

endmodule

// File: rtl/onchip_sram_responder.sv
// Scratchpad + CSR window slave for the matrix accelerator. Optional per-byte
// parity checking is enabled by defining MM_PARITY_EN.
module onchip_sram_responder
  import fecg_mm_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  onchip_sram_responder_if.slave  bus,
  input  logic                    done_in,
  output logic                    start,
  output logic [15:0]             size_m,
  output logic [15:0]             size_n,
  output logic [15:0]             size_p,
  output logic                    parity_err
);
  localparam int RAM_AW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] CSR_BASE = ADDR_W'(2**ADDR_W - 4);
  localparam logic [ADDR_W-1:0] RAM_TOP  = ADDR_W'(DEPTH);

  logic en, accept, rd_acc, wr_acc, proto_hit, addr_hit, par_hit;
  logic is_ram, is_csr, st_wr, start_set;
  logic [1:0] csr_off;
  logic [2:0] w1c;
  logic [DATA_W-1:0] csr_rdata, ram_q;
  logic par_mis;
  csr_status_t status;
  logic start_q;

  assign en        = bus.clk_en;
  assign accept    = bus.chip_select & en & (bus.read | bus.write);
  assign wr_acc    = accept & bus.write;
  assign rd_acc    = accept & bus.read & ~bus.write;
  assign proto_hit = accept & bus.read & bus.write;
  assign is_ram    = bus.address < RAM_TOP;
  assign is_csr    = bus.address >= CSR_BASE;
  assign addr_hit  = accept & ~is_ram & ~is_csr;
  assign csr_off   = bus.address[1:0];

  sram_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(RAM_AW)) u_bank (
    .clk     (clk),
    .wr_en   (wr_acc & is_ram),
    .rd_en   (rd_acc & is_ram),
    .addr    (bus.address[RAM_AW-1:0]),
    .be      (bus.byte_enable),
    .wdata   (bus.write_data),
    .rdata   (ram_q),
    .par_mis (par_mis)
  );

  always_comb begin
    csr_rdata = '0;
    case (csr_off)
      CSR_SIZE_M: csr_rdata[15:0] = size_m;
      CSR_SIZE_N: csr_rdata[15:0] = size_n;
      CSR_SIZE_P: csr_rdata[15:0] = size_p;
      default: begin
        csr_rdata[ST_DONE]  = status.done;
        csr_rdata[ST_PROTO] = status.proto_err;
        csr_rdata[ST_ADDR]  = status.addr_err;
        csr_rdata[ST_PAR]   = status.par_err;
      end
    endcase
  end

  function automatic logic [15:0] lane_merge(input logic [15:0] cur,
                                             input logic [15:0] wd,
                                             input logic [1:0]  be);
    return {be[1] ? wd[15:8] : cur[15:8], be[0] ? wd[7:0] : cur[7:0]};
  endfunction

  assign st_wr     = wr_acc & is_csr & (csr_off == CSR_STATUS) & bus.byte_enable[0];
  assign start_set = st_wr & bus.write_data[ST_START];
  assign w1c       = st_wr ? bus.write_data[ST_PAR:ST_PROTO] : 3'b000;

  always_ff @(posedge clk) begin
    if (reset) begin
      size_m  <= DIM_RST;
      size_n  <= DIM_RST;
      size_p  <= DIM_RST;
      status  <= '0;
      start_q <= 1'b0;
    end else if (en) begin
      if (wr_acc && is_csr && csr_off == CSR_SIZE_M)
        size_m <= lane_merge(size_m, bus.write_data[15:0], bus.byte_enable[1:0]);
      if (wr_acc && is_csr && csr_off == CSR_SIZE_N)
        size_n <= lane_merge(size_n, bus.write_data[15:0], bus.byte_enable[1:0]);
      if (wr_acc && is_csr && csr_off == CSR_SIZE_P)
        size_p <= lane_merge(size_p, bus.write_data[15:0], bus.byte_enable[1:0]);
      start_q <= start_set;
      // A start write clears done even if done_in arrives in the same cycle.
      status.done      <= start_set ? 1'b0 : (status.done | done_in);
      status.proto_err <= proto_hit | (status.proto_err & ~w1c[0]);
      status.addr_err  <= addr_hit  | (status.addr_err  & ~w1c[1]);
      status.par_err   <= par_hit   | (status.par_err   & ~w1c[2]);
    end
  end

  // Stage 1 aligns with the bank's registered read; CSR/hole data rides alongside.
  logic s1_v, s1_ram, s1_perr;
  logic [DATA_W-1:0] s1_data, s1_res;
  logic resp_v, resp_perr, valid_o;
  logic [DATA_W-1:0] resp_data, rd_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v    <= 1'b0;
      s1_ram  <= 1'b0;
      s1_data <= '0;
    end else if (en) begin
      s1_v    <= rd_acc;
      s1_ram  <= is_ram;
      s1_data <= is_csr ? csr_rdata : '0;
    end
  end

  assign s1_res  = s1_ram ? ram_q : s1_data;
  assign s1_perr = s1_ram & par_mis;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic s2_v, s2_perr;
      logic [DATA_W-1:0] s2_data;
      always_ff @(posedge clk) begin
        if (reset) begin
          s2_v    <= 1'b0;
          s2_perr <= 1'b0;
          s2_data <= '0;
        end else if (en) begin
          s2_v    <= s1_v;
          s2_perr <= s1_perr;
          s2_data <= s1_res;
        end
      end
      assign resp_v    = s2_v;
      assign resp_perr = s2_perr;
      assign resp_data = s2_data;
    end else begin : g_lat1
      assign resp_v    = s1_v;
      assign resp_perr = s1_perr;
      assign resp_data = s1_res;
    end
  endgenerate

  // A response pending while clk_en is low is held and delivered on the next enabled cycle.
  assign valid_o  = resp_v & en;
  assign par_hit  = valid_o & resp_perr;
  assign bus.valid     = valid_o;
  assign bus.read_data = valid_o ? resp_data : rd_hold;
  assign start         = start_q & en;

  always_ff @(posedge clk) begin
    if (reset)        rd_hold <= '0;
    else if (valid_o) rd_hold <= resp_data;
  end

`ifdef MM_PARITY_EN
  assign parity_err = par_hit;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_onchip_sram_responder.sv
// Scoreboard bench for onchip_sram_responder; parity checks run when MM_PARITY_EN is defined.
module tb_onchip_sram_responder;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4096;
  localparam int LAT    = 1;
  localparam logic [13:0] CSR_BASE = 14'h3FFC;
  localparam logic [13:0] CSR_ST   = 14'h3FFF;

  typedef struct packed {
    logic [31:0] data;
    logic        perr;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset, done_in, start, parity_err;
  logic [15:0] size_m, size_n, size_p;
  int n_chk = 0, n_err = 0, en_cnt = 0, start_cnt = 0, n_valid = 0;
  exp_t sb[$];
  exp_t e;
  logic [31:0] model [16];

  always #5 clk = ~clk;

  onchip_sram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  onchip_sram_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                          .READ_LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .done_in    (done_in),
    .start      (start),
    .size_m     (size_m),
    .size_n     (size_n),
    .size_p     (size_p),
    .parity_err (parity_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) if (bus.clk_en) en_cnt <= en_cnt + 1;

  always @(negedge clk) begin
    if (start) start_cnt++;
    if (bus.valid) begin
      n_valid++;
      chk("valid_en", {31'b0, bus.clk_en}, 32'd1);
      if (sb.size() == 0) chk("unexpected_valid", {31'b0, bus.valid}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("rd_data", bus.read_data, e.data);
        chk("rd_lat", en_cnt, e.due);
        chk("parity_err", {31'b0, parity_err}, {31'b0, e.perr});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.chip_select = 1'b0; bus.read = 1'b0; bus.write = 1'b0; done_in = 1'b0;
    step();
  endtask

  task automatic do_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.chip_select = 1'b1; bus.read = 1'b0; bus.write = 1'b1;
    bus.address = a; bus.write_data = d; bus.byte_enable = be;
    if (a < 14'd16)
      for (int i = 0; i < 4; i++) if (be[i]) model[a[3:0]][i*8 +: 8] = d[i*8 +: 8];
    step();
  endtask

  task automatic do_read(input logic [13:0] a, input logic [31:0] exp, input logic p = 1'b0);
    exp_t x;
    bus.chip_select = 1'b1; bus.read = 1'b1; bus.write = 1'b0;
    bus.address = a; bus.byte_enable = 4'h0;
    x.data = exp; x.perr = p; x.due = en_cnt + LAT;
    sb.push_back(x);
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int v0;
    reset = 1'b1; done_in = 1'b0;
    bus.clk_en = 1'b1; bus.chip_select = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.address = '0; bus.byte_enable = '0; bus.write_data = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (3) step();
    chk("rst_valid", {31'b0, bus.valid}, 32'd0);
    chk("rst_rdata", bus.read_data, 32'd0);
    chk("rst_size_m", {16'b0, size_m}, 32'd8);
    chk("rst_size_n", {16'b0, size_n}, 32'd8);
    chk("rst_size_p", {16'b0, size_p}, 32'd8);
    chk("rst_perr", {31'b0, parity_err}, 32'd0);
    reset = 1'b0;
    step();

    // CSR reset values
    do_read(CSR_BASE, 32'd8);
    do_read(CSR_BASE + 14'd1, 32'd8);
    do_read(CSR_BASE + 14'd2, 32'd8);
    do_read(CSR_ST, 32'd0);
    idle(); drain();
    chk("start_quiet", start_cnt, 32'd0);

    // byte lanes, read-after-write, be=0 no-op
    do_write(14'd5, 32'hFFFF_FFFF, 4'hF);
    do_write(14'd5, 32'hA5A5_1234, 4'b0101);
    do_read(14'd5, 32'hFFA5_FF34);
    do_write(14'd5, 32'h0000_0000, 4'h0);
    do_read(14'd5, model[5]);
    idle(); drain();

    // burst with clk_en gap
    for (int i = 0; i < 8; i++) do_write(14'(i), 32'hC0DE_0000 | (32'(i) * 32'h0101), 4'hF);
    v0 = n_valid;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        bus.clk_en = 1'b0; bus.chip_select = 1'b1; bus.read = 1'b1; bus.address = 14'd4;
        repeat (3) step();
        bus.clk_en = 1'b1;
      end
      do_read(14'(i), model[i]);
    end
    idle(); drain();
    chk("burst_count", n_valid - v0, 32'd8);

    // read & write together
    bus.chip_select = 1'b1; bus.read = 1'b1; bus.write = 1'b1;
    bus.address = 14'd9; bus.write_data = 32'h1; bus.byte_enable = 4'hF;
    model[9] = 32'h1;
    step();
    idle(); idle();
    do_read(14'd9, model[9]);
    do_read(CSR_ST, 32'h4);
    do_write(CSR_ST, 32'h4, 4'h1);
    do_read(CSR_ST, 32'h0);
    idle(); drain();

    // address hole, start/done handshake
    do_read(14'(DEPTH), 32'h0);
    do_read(CSR_ST, 32'h8);
    idle();
    done_in = 1'b1; step(); done_in = 1'b0;
    do_read(CSR_ST, 32'hA);
    do_write(CSR_ST, 32'h1, 4'h1);
    do_read(CSR_ST, 32'h8);
    do_write(CSR_ST, 32'h8, 4'h1);
    do_read(CSR_ST, 32'h0);
    idle();
    done_in = 1'b1; step(); done_in = 1'b0;
    do_read(CSR_ST, 32'h2);
    done_in = 1'b1;
    do_write(CSR_ST, 32'h1, 4'h1);
    done_in = 1'b0;
    do_read(CSR_ST, 32'h0);
    idle(); drain();
    chk("start_pulses", start_cnt, 32'd2);

    // parity
    do_write(14'd3, 32'h0F0F_1234, 4'hF);
    do_read(14'd3, model[3]);
    idle(); drain();
`ifdef MM_PARITY_EN
    dut.u_bank.mem[3] = dut.u_bank.mem[3] ^ 32'h0000_0100;
    do_read(14'd3, model[3] ^ 32'h0000_0100, 1'b1);
    do_read(CSR_ST, 32'h10);
    do_write(CSR_ST, 32'h10, 4'h1);
    do_read(CSR_ST, 32'h0);
    idle(); drain();
`endif

    // reset during an in-flight read
    do_write(CSR_BASE, 32'h0000_0033, 4'b0011);
    idle();
    chk("size_m_wr", {16'b0, size_m}, 32'h33);
    bus.chip_select = 1'b1; bus.read = 1'b1; bus.write = 1'b0; bus.address = 14'd5;
    reset = 1'b1;
    step();
    bus.chip_select = 1'b0; bus.read = 1'b0;
    step();
    reset = 1'b0;
    repeat (3) step();
    chk("post_rst_size_m", {16'b0, size_m}, 32'd8);
    chk("post_rst_rdata", bus.read_data, 32'd0);
    chk("post_rst_valid", {31'b0, bus.valid}, 32'd0);
    do_read(14'd5, model[5]);
    idle(); drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
